// File: rtl/beef_mem_pkg.sv
// Shared types and sizing for the BeeF tape-memory responder.
package beef_mem_pkg;

    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RESP
    } state_t;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/tape_ram.sv
// Single-port tape RAM: one write or one read per cycle, registered read data.
module tape_ram
    import beef_mem_pkg::*;
#(
    parameter int unsigned AddrWidth = ADDR_WIDTH,
    parameter int unsigned DataWidth = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [DataWidth-1:0] i_wdata,
    output logic [DataWidth-1:0] o_rdata
);

    localparam int unsigned Depth = depth_of(AddrWidth);

    logic [DataWidth-1:0] r_mem [Depth];
    logic [DataWidth-1:0] r_rdata;

    // The array carries no reset; zeroing is the responder's job.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tape_mem_responder.sv
// Far end of the BeeF tape-memory interface: zero-fills the tape after reset,
// then serves read/write requests with a held valid/ready read response.
module tape_mem_responder
    import beef_mem_pkg::*;
#(
    parameter int unsigned AddrWidth    = ADDR_WIDTH,
    parameter int unsigned DataWidth    = DATA_WIDTH,
    parameter bit          ClearOnReset = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DataWidth-1:0] resp_data,
    output logic                 clearing
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AddrWidth-1:0] r_clear_cnt;

    logic                 w_req_ready;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_ram_we;
    logic [AddrWidth-1:0] w_ram_addr;
    logic [DataWidth-1:0] w_ram_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ClearOnReset ? ST_CLEAR : ST_IDLE;
            r_clear_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clear_cnt <= r_clear_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_req_ready = (r_state != ST_CLEAR) && ((r_state != ST_RESP) || resp_ready);
        w_rd        = req_valid && w_req_ready && !req_write && !reset;
        w_wr        = req_valid && w_req_ready &&  req_write && !reset;
        w_state_nxt = r_state;
        w_ram_we    = w_wr;
        w_ram_addr  = req_addr;
        w_ram_wdata = req_wdata;
        case (r_state)
            ST_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_clear_cnt;
                w_ram_wdata = '0;
                if (r_clear_cnt == '1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_rd) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                // A read accepted alongside the consume keeps the channel full.
                if (w_rd) begin
                    w_state_nxt = ST_RESP;
                end else if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    tape_ram #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_ram_we),
        .i_re    (w_rd),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (resp_data)
    );

    assign req_ready  = w_req_ready;
    assign resp_valid = (r_state == ST_RESP);
    assign clearing   = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_tape_mem_responder.sv
// Directed bench for tape_mem_responder: one instance zero-fills after reset, one does not.
module tb_tape_mem_responder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset = 1'b1, a_req_valid = 1'b0, a_req_write = 1'b0, a_resp_ready = 1'b1;
    logic [7:0] a_req_addr = '0, a_req_wdata = '0;
    logic       a_req_ready, a_resp_valid, a_clearing;
    logic [7:0] a_resp_data;

    logic       b_reset = 1'b1, b_req_valid = 1'b0, b_req_write = 1'b0, b_resp_ready = 1'b1;
    logic [7:0] b_req_addr = '0, b_req_wdata = '0;
    logic       b_req_ready, b_resp_valid, b_clearing;
    logic [7:0] b_resp_data;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        b_clr_seen = 1'b0;

    tape_mem_responder #(.AddrWidth(8), .DataWidth(8), .ClearOnReset(1'b1)) dut_a (
        .clk(clk), .reset(a_reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data),
        .clearing(a_clearing)
    );

    tape_mem_responder #(.AddrWidth(8), .DataWidth(8), .ClearOnReset(1'b0)) dut_b (
        .clk(clk), .reset(b_reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
        .clearing(b_clearing)
    );

    always @(negedge clk) begin
        if (!b_reset && b_clearing === 1'b1) b_clr_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse reset for one edge, then count cycles with clearing high (bounded).
    task automatic reset_and_clear(input string tag);
        int unsigned n = 0;
        logic        rdy_seen = 1'b0;
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        while (a_clearing === 1'b1 && n < 1000) begin
            n++;
            if (a_req_ready !== 1'b0) rdy_seen = 1'b1;
            @(negedge clk);
        end
        check({tag, "_clr_cycles"}, n, 256);
        check({tag, "_rdy_low"}, {31'd0, rdy_seen}, 0);
        check({tag, "_clr_done"}, {31'd0, a_clearing}, 0);
    endtask

    task automatic a_write(input logic [7:0] addr, input logic [7:0] data);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = addr; a_req_wdata = data;
        #1 check("wr_rdy", {31'd0, a_req_ready}, 1);
        @(negedge clk);
        a_req_valid = 1'b0; a_req_write = 1'b0;
    endtask

    task automatic a_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        a_resp_ready = 1'b1;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = addr;
        #1 check({tag, "_rdy"}, {31'd0, a_req_ready}, 1);
        @(negedge clk);
        a_req_valid = 1'b0;
        check({tag, "_vld"}, {31'd0, a_resp_valid}, 1);
        check({tag, "_data"}, {24'd0, a_resp_data}, {24'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp4 [3];
        exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33;

        @(negedge clk);
        @(negedge clk);
        b_reset = 1'b0;
        check("rst_clearing", {31'd0, a_clearing}, 1);
        check("rst_rdy", {31'd0, a_req_ready}, 0);
        check("rst_vld", {31'd0, a_resp_valid}, 0);
        check("rst_data", {24'd0, a_resp_data}, 0);
        a_reset = 1'b0;
        while (a_clearing === 1'b1) @(negedge clk);

        // 1: dirty the tape, reset, and confirm the fill wipes it
        a_write(8'h00, 8'hDE); a_write(8'h7F, 8'hAD); a_write(8'hFF, 8'hBE);
        a_read("pre", 8'h7F, 8'hAD);
        reset_and_clear("t1");
        a_read("t1_r00", 8'h00, 8'h00);
        a_read("t1_r7f", 8'h7F, 8'h00);
        a_read("t1_rff", 8'hFF, 8'h00);

        // 2: read-after-write in consecutive cycles
        a_write(8'h10, 8'h5A);
        a_read("t2_raw", 8'h10, 8'h5A);

        // 3: backpressured response, then write while consuming
        a_resp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h10;
        @(negedge clk);
        a_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_vld", {31'd0, a_resp_valid}, 1);
            check("t3_hold_data", {24'd0, a_resp_data}, 32'h5A);
            check("t3_hold_rdy", {31'd0, a_req_ready}, 0);
            @(negedge clk);
        end
        a_resp_ready = 1'b1;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h10; a_req_wdata = 8'h33;
        #1 check("t3_wr_rdy", {31'd0, a_req_ready}, 1);
        check("t3_data_same", {24'd0, a_resp_data}, 32'h5A);
        @(negedge clk);
        a_req_valid = 1'b0; a_req_write = 1'b0;
        check("t3_vld_drop", {31'd0, a_resp_valid}, 0);
        check("t3_data_kept", {24'd0, a_resp_data}, 32'h5A);
        a_read("t3_new", 8'h10, 8'h33);

        // 4: back-to-back reads at full throughput
        a_write(8'h01, 8'h11); a_write(8'h02, 8'h22); a_write(8'h03, 8'h33);
        a_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                check("t4_vld", {31'd0, a_resp_valid}, 1);
                check("t4_data", {24'd0, a_resp_data}, {24'd0, exp4[i-1]});
            end
            if (i < 3) begin
                a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'(i + 1);
                #1 check("t4_rdy", {31'd0, a_req_ready}, 1);
            end else begin
                a_req_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("t4_idle", {31'd0, a_resp_valid}, 0);

        // 5: reset while a response is pending
        a_write(8'h20, 8'hAB);
        a_resp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h20;
        @(negedge clk);
        a_req_valid = 1'b0;
        check("t5_pend", {24'd0, a_resp_data}, 32'hAB);
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        a_resp_ready = 1'b1;
        check("t5_vld_drop", {31'd0, a_resp_valid}, 0);
        check("t5_clearing", {31'd0, a_clearing}, 1);
        reset_and_clear("t5");
        a_read("t5_r20", 8'h20, 8'h00);

        // 6: no zero-fill; first cycle after reset takes a request
        b_reset = 1'b1;
        @(negedge clk);
        b_reset = 1'b0;
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 8'hFF; b_req_wdata = 8'hFF;
        #1 check("t6_rdy", {31'd0, b_req_ready}, 1);
        check("t6_clr", {31'd0, b_clearing}, 0);
        @(negedge clk);
        b_req_write = 1'b0;
        @(negedge clk);
        b_req_valid = 1'b0;
        check("t6_vld", {31'd0, b_resp_valid}, 1);
        check("t6_data", {24'd0, b_resp_data}, 32'hFF);
        @(negedge clk);
        check("t6_never_clr", {31'd0, b_clr_seen}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
